// File: rtl/spi_word_exchange_buffer.sv
// spi_word_exchange_buffer
// Full-duplex word buffer between an SPI slave byte shifter and a host bus.
// Each SPI byte event captures one received byte, which is packed MSB-first
// into DATA_WIDTH words in rx_mem. The same event presents the next transmit
// byte, unpacked MSB-first from words in tx_mem. Frames are delimited by
// spi_frame. The block reports a per-frame word count and a sticky overflow
// flag, and gives the host random access to both memories.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   spi_ready       - byte-complete level from the shifter (rising edge = event)
//   spi_frame       - chip-select active level
//   spi_data_in     - received byte
//   spi_data_out    - registered next byte to transmit
//   host_wr*        - TX memory write port
//   host_rd_addr    - RX memory read address
//   host_rd_data    - registered RX read data
//   frame_done      - one-cycle pulse at frame end
//   rx_count        - complete words received in the last finished frame
//   overflow        - sticky overflow flag for the current or last frame
module spi_word_exchange_buffer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SPI_DATA_WIDTH = 8,
    parameter int unsigned BUF_SIZE       = 6,
    localparam int unsigned BPW        = DATA_WIDTH / SPI_DATA_WIDTH,
    localparam int unsigned ADDR_WIDTH = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1,
    localparam int unsigned CNT_WIDTH  = $clog2(BUF_SIZE + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spi_ready,
    input  logic                      spi_frame,
    input  logic [SPI_DATA_WIDTH-1:0] spi_data_in,
    output logic [SPI_DATA_WIDTH-1:0] spi_data_out,
    input  logic                      host_wr,
    input  logic [ADDR_WIDTH-1:0]     host_wr_addr,
    input  logic [DATA_WIDTH-1:0]     host_wr_data,
    input  logic [ADDR_WIDTH-1:0]     host_rd_addr,
    output logic [DATA_WIDTH-1:0]     host_rd_data,
    output logic                      frame_done,
    output logic [CNT_WIDTH-1:0]      rx_count,
    output logic                      overflow
);

    localparam int unsigned BCNT_WIDTH = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_WIDTH-1:0] rx_mem [BUF_SIZE];
    logic [DATA_WIDTH-1:0] tx_mem [BUF_SIZE];

    logic                      ready_q,        ready_d;
    logic                      frame_q,        frame_d;
    logic                      armed_q,        armed_d;
    logic                      in_frame_q,     in_frame_d;
    logic [CNT_WIDTH-1:0]      word_addr_q,    word_addr_d;
    logic [BCNT_WIDTH-1:0]     byte_cnt_q,     byte_cnt_d;
    logic [DATA_WIDTH-1:0]     rx_shift_q,     rx_shift_d;
    logic [DATA_WIDTH-1:0]     tx_shift_q,     tx_shift_d;
    logic [SPI_DATA_WIDTH-1:0] spi_data_out_q, spi_data_out_d;
    logic [DATA_WIDTH-1:0]     host_rd_data_q, host_rd_data_d;
    logic                      frame_done_q,   frame_done_d;
    logic [CNT_WIDTH-1:0]      rx_count_q,     rx_count_d;
    logic                      overflow_q,     overflow_d;

    logic                  start_c;
    logic                  end_c;
    logic                  event_c;
    logic [31:0]           reload_idx_c;
    logic [DATA_WIDTH-1:0] tx_word_c;
    logic [DATA_WIDTH-1:0] rx_word_c;
    logic                  rx_we_c;
    logic [ADDR_WIDTH-1:0] rx_waddr_c;

    // Frame and byte event detection. armed_q requires spi_frame to be seen
    // low after reset, so a frame cut by reset is never resumed mid-way;
    // in_frame_q keeps events and frame_done confined to properly started frames.
    assign start_c = spi_frame & ~frame_q & armed_q;
    assign end_c   = ~spi_frame & frame_q & in_frame_q;
    assign event_c = spi_ready & ~ready_q & spi_frame & in_frame_q & ~start_c;

    // Word to load into the TX shifter: word 0 at frame start, otherwise the
    // word after the one just finished; a same-cycle host write wins.
    always_comb begin
        reload_idx_c = start_c ? 32'd0 : 32'(word_addr_q) + 32'd1;
        tx_word_c    = '0;
        if (reload_idx_c < BUF_SIZE) begin
            if (host_wr && (32'(host_wr_addr) == reload_idx_c)) begin
                tx_word_c = host_wr_data;
            end else begin
                tx_word_c = tx_mem[ADDR_WIDTH'(reload_idx_c)];
            end
        end
    end

    assign rx_word_c = DATA_WIDTH'({rx_shift_q, spi_data_in});

    // Next-state logic for the frame, byte and word bookkeeping.
    always_comb begin
        ready_d        = spi_ready;
        frame_d        = spi_frame;
        armed_d        = armed_q | ~spi_frame;
        in_frame_d     = in_frame_q;
        word_addr_d    = word_addr_q;
        byte_cnt_d     = byte_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        spi_data_out_d = spi_data_out_q;
        frame_done_d   = 1'b0;
        rx_count_d     = rx_count_q;
        overflow_d     = overflow_q;
        rx_we_c        = 1'b0;
        rx_waddr_c     = ADDR_WIDTH'(word_addr_q);

        if (start_c) begin
            in_frame_d     = 1'b1;
            word_addr_d    = '0;
            byte_cnt_d     = '0;
            overflow_d     = 1'b0;
            tx_shift_d     = tx_word_c << SPI_DATA_WIDTH;
            spi_data_out_d = tx_word_c[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
        end else if (event_c) begin
            if (32'(word_addr_q) < BUF_SIZE) begin
                rx_shift_d = rx_word_c;
                if (byte_cnt_q == BCNT_WIDTH'(BPW - 1)) begin
                    rx_we_c        = 1'b1;
                    word_addr_d    = word_addr_q + CNT_WIDTH'(1);
                    byte_cnt_d     = '0;
                    tx_shift_d     = tx_word_c << SPI_DATA_WIDTH;
                    spi_data_out_d = tx_word_c[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
                end else begin
                    byte_cnt_d     = byte_cnt_q + BCNT_WIDTH'(1);
                    tx_shift_d     = tx_shift_q << SPI_DATA_WIDTH;
                    spi_data_out_d = tx_shift_q[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
                end
            end else begin
                overflow_d     = 1'b1;
                spi_data_out_d = '0;
            end
        end

        // A partial word is simply dropped: only completed words are counted.
        if (end_c) begin
            in_frame_d   = 1'b0;
            frame_done_d = 1'b1;
            rx_count_d   = word_addr_d;
        end
    end

    // Registered host read; out-of-range addresses read as zero.
    always_comb begin
        host_rd_data_d = '0;
        if (32'(host_rd_addr) < BUF_SIZE) begin
            host_rd_data_d = rx_mem[host_rd_addr];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q        <= 1'b0;
            frame_q        <= 1'b0;
            armed_q        <= 1'b0;
            in_frame_q     <= 1'b0;
            word_addr_q    <= '0;
            byte_cnt_q     <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            spi_data_out_q <= '0;
            host_rd_data_q <= '0;
            frame_done_q   <= 1'b0;
            rx_count_q     <= '0;
            overflow_q     <= 1'b0;
        end else begin
            ready_q        <= ready_d;
            frame_q        <= frame_d;
            armed_q        <= armed_d;
            in_frame_q     <= in_frame_d;
            word_addr_q    <= word_addr_d;
            byte_cnt_q     <= byte_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            spi_data_out_q <= spi_data_out_d;
            host_rd_data_q <= host_rd_data_d;
            frame_done_q   <= frame_done_d;
            rx_count_q     <= rx_count_d;
            overflow_q     <= overflow_d;
        end
    end

    // Memories: no reset, contents persist across frames.
    always_ff @(posedge clk) begin
        if (rx_we_c) begin
            rx_mem[rx_waddr_c] <= rx_word_c;
        end
        if (host_wr && (32'(host_wr_addr) < BUF_SIZE)) begin
            tx_mem[host_wr_addr] <= host_wr_data;
        end
    end

    assign spi_data_out = spi_data_out_q;
    assign host_rd_data = host_rd_data_q;
    assign frame_done   = frame_done_q;
    assign rx_count     = rx_count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_spi_word_exchange_buffer.sv
// Directed self-checking bench for spi_word_exchange_buffer.
module tb_spi_word_exchange_buffer;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 8;
    localparam int unsigned BS = 6;
    localparam int unsigned AW = 3;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          spi_ready;
    logic          spi_frame;
    logic [SW-1:0] spi_data_in;
    logic [SW-1:0] spi_data_out;
    logic          host_wr;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic [AW-1:0] host_rd_addr;
    logic [DW-1:0] host_rd_data;
    logic          frame_done;
    logic [CW-1:0] rx_count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    spi_word_exchange_buffer #(
        .DATA_WIDTH    (DW),
        .SPI_DATA_WIDTH(SW),
        .BUF_SIZE      (BS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_ready   (spi_ready),
        .spi_frame   (spi_frame),
        .spi_data_in (spi_data_in),
        .spi_data_out(spi_data_out),
        .host_wr     (host_wr),
        .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data),
        .host_rd_addr(host_rd_addr),
        .host_rd_data(host_rd_data),
        .frame_done  (frame_done),
        .rx_count    (rx_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Counts every cycle frame_done is high, so a stretched pulse is visible.
    always @(negedge clk) begin
        if (rst_n && frame_done) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        host_wr      = 1'b1;
        host_wr_addr = addr;
        host_wr_data = data;
        tick(1);
        host_wr      = 1'b0;
    endtask

    task automatic read_rx(input logic [AW-1:0] addr, output logic [DW-1:0] data);
        host_rd_addr = addr;
        tick(1);
        data = host_rd_data;
    endtask

    task automatic send_byte(input logic [SW-1:0] b, input int hold);
        spi_data_in = b;
        spi_ready   = 1'b1;
        tick(hold);
        spi_ready   = 1'b0;
        tick(2);
    endtask

    task automatic frame_begin();
        spi_frame = 1'b1;
        tick(3);
    endtask

    task automatic frame_end();
        spi_frame = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        spi_ready    = 1'b0;
        spi_frame    = 1'b0;
        spi_data_in  = '0;
        host_wr      = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        host_rd_addr = 3'd7;
        tick(3);
        n_checks++;
        if ({spi_data_out, host_rd_data, frame_done, rx_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: out=%h rd=%h done=%b cnt=%0d ovf=%b expected all 0",
                     spi_data_out, host_rd_data, frame_done, rx_count, overflow);
        end
        rst_n = 1'b1;
        tick(3);
        n_checks++;
        if ({spi_data_out, host_rd_data, frame_done, rx_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: out=%h rd=%h done=%b cnt=%0d ovf=%b expected all 0",
                     spi_data_out, host_rd_data, frame_done, rx_count, overflow);
        end
        n_checks++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: frame_done cycles=%0d expected 0", done_cnt);
        end
    endtask

    // One-word exchange: tx_mem[0]=A1B2C3D4, tx_mem[1]=55667788 preloaded.
    task automatic run_word_frame(input int hold, input bit rewrite_word0, input string tag);
        logic [SW-1:0] rx_b  [4];
        logic [SW-1:0] exp_b [4];
        logic [DW-1:0] rd;
        int d0;
        rx_b  = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_b = '{8'hB2, 8'hC3, 8'hD4, 8'h55};
        d0 = done_cnt;
        frame_begin();
        n_checks++;
        if (spi_data_out !== 8'hA1) begin
            n_fail++;
            $display("FAIL %s_start: spi_data_out=%h expected a1", tag, spi_data_out);
        end
        // Word 0 already sits in the shifter; overwriting it must not disturb this frame.
        if (rewrite_word0) host_write(3'd0, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            send_byte(rx_b[i], hold);
            n_checks++;
            if (spi_data_out !== exp_b[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d: spi_data_out=%h expected %h", tag, i, spi_data_out, exp_b[i]);
            end
        end
        frame_end();
        n_checks++;
        if (done_cnt !== d0 + 1) begin
            n_fail++;
            $display("FAIL %s_done: frame_done cycles=%0d expected 1", tag, done_cnt - d0);
        end
        n_checks++;
        if (rx_count !== 3'd1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_count: rx_count=%0d ovf=%b expected 1 0", tag, rx_count, overflow);
        end
        read_rx(3'd0, rd);
        n_checks++;
        if (rd !== 32'h11223344) begin
            n_fail++;
            $display("FAIL %s_rxword: rx_mem[0]=%h expected 11223344", tag, rd);
        end
    endtask

    task automatic test_loopback();
        host_write(3'd0, 32'hA1B2C3D4);
        host_write(3'd1, 32'h55667788);
        run_word_frame(1, 1'b0, "loop");
    endtask

    task automatic test_partial();
        logic [DW-1:0] rd;
        frame_begin();
        for (int k = 1; k <= 6; k++) send_byte(8'(k), 1);
        n_checks++;
        if (spi_data_out !== 8'h77) begin
            n_fail++;
            $display("FAIL partial_txbyte: spi_data_out=%h expected 77", spi_data_out);
        end
        frame_end();
        n_checks++;
        if (rx_count !== 3'd1) begin
            n_fail++;
            $display("FAIL partial_count: rx_count=%0d expected 1", rx_count);
        end
        read_rx(3'd0, rd);
        n_checks++;
        if (rd !== 32'h01020304) begin
            n_fail++;
            $display("FAIL partial_rxword: rx_mem[0]=%h expected 01020304", rd);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] rd;
        logic [SW-1:0] exp_b;
        int d0;
        // tx word i holds bytes 16i+1 .. 16i+4, MSB first
        for (int i = 0; i < 6; i++)
            host_write(3'(i), {8'(16*i+1), 8'(16*i+2), 8'(16*i+3), 8'(16*i+4)});
        d0 = done_cnt;
        frame_begin();
        n_checks++;
        if (spi_data_out !== 8'h01) begin
            n_fail++;
            $display("FAIL ovf_start: spi_data_out=%h expected 01", spi_data_out);
        end
        for (int k = 1; k <= 28; k++) begin
            send_byte(8'(k), 1);
            exp_b = (k < 24) ? 8'(16*(k/4) + (k%4) + 1) : 8'h00;
            n_checks++;
            if (spi_data_out !== exp_b) begin
                n_fail++;
                $display("FAIL ovf_txbyte%0d: spi_data_out=%h expected %h", k, spi_data_out, exp_b);
            end
            n_checks++;
            if (overflow !== (k >= 25)) begin
                n_fail++;
                $display("FAIL ovf_flag%0d: overflow=%b expected %b", k, overflow, (k >= 25));
            end
        end
        frame_end();
        n_checks++;
        if (rx_count !== 3'd6 || overflow !== 1'b1 || done_cnt !== d0 + 1) begin
            n_fail++;
            $display("FAIL ovf_end: rx_count=%0d ovf=%b done=%0d expected 6 1 1",
                     rx_count, overflow, done_cnt - d0);
        end
        read_rx(3'd0, rd);
        n_checks++;
        if (rd !== 32'h01020304) begin
            n_fail++;
            $display("FAIL ovf_rx0: rx_mem[0]=%h expected 01020304", rd);
        end
        read_rx(3'd5, rd);
        n_checks++;
        if (rd !== 32'h15161718) begin
            n_fail++;
            $display("FAIL ovf_rx5: rx_mem[5]=%h expected 15161718", rd);
        end
        read_rx(3'd6, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL ovf_rd_oor: rd[6]=%h expected 0", rd);
        end
        frame_begin();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: overflow=%b expected 0", overflow);
        end
        frame_end();
        n_checks++;
        if (rx_count !== 3'd0) begin
            n_fail++;
            $display("FAIL ovf_empty: rx_count=%0d expected 0", rx_count);
        end
    endtask

    task automatic test_long_ready();
        host_write(3'd0, 32'hA1B2C3D4);
        host_write(3'd1, 32'h55667788);
        run_word_frame(10, 1'b1, "long");
    endtask

    task automatic test_mid_reset();
        logic [SW-1:0] rx_b [4];
        logic [DW-1:0] rd;
        int d0;
        rx_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        d0 = done_cnt;
        frame_begin();
        send_byte(8'h99, 1);
        send_byte(8'h98, 1);
        rst_n = 1'b0;
        tick(2);
        n_checks++;
        if (spi_data_out !== 8'h00 || rx_count !== 3'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mrst_hold: out=%h cnt=%0d ovf=%b expected 0 0 0",
                     spi_data_out, rx_count, overflow);
        end
        rst_n = 1'b1;
        tick(2);
        frame_end();
        n_checks++;
        if (done_cnt !== d0) begin
            n_fail++;
            $display("FAIL mrst_no_done: frame_done cycles=%0d expected 0", done_cnt - d0);
        end
        frame_begin();
        n_checks++;
        if (spi_data_out !== 8'hDE) begin
            n_fail++;
            $display("FAIL mrst_start: spi_data_out=%h expected de", spi_data_out);
        end
        for (int i = 0; i < 4; i++) send_byte(rx_b[i], 1);
        frame_end();
        n_checks++;
        if (rx_count !== 3'd1 || done_cnt !== d0 + 1) begin
            n_fail++;
            $display("FAIL mrst_count: rx_count=%0d done=%0d expected 1 1", rx_count, done_cnt - d0);
        end
        read_rx(3'd0, rd);
        n_checks++;
        if (rd !== 32'hAABBCCDD) begin
            n_fail++;
            $display("FAIL mrst_rxword: rx_mem[0]=%h expected aabbccdd", rd);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_partial();
        test_overflow();
        test_long_ready();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
